// File: rtl/interface_tx_pkg.sv
// ----------------------------------------------------------------------------
// interface_tx_pkg
// Shared definitions for the ALU-to-UART response path: state encoding,
// status byte bit positions and frame lengths. The frame lengths and status
// bit positions are shared with the receive-side byte definitions.
// ----------------------------------------------------------------------------
package interface_tx_pkg;

    localparam int DATA_W = 8;

    // State encoding
    localparam logic [1:0] IDLE      = 2'b00;
    localparam logic [1:0] SEND      = 2'b01;
    localparam logic [1:0] WAIT_DONE = 2'b10;
    localparam logic [1:0] DONE      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = IDLE,
        ST_SEND      = SEND,
        ST_WAIT_DONE = WAIT_DONE,
        ST_DONE      = DONE
    } tx_state_t;

    // Status byte layout
    localparam int STATUS_CARRY_BIT = 0;
    localparam int STATUS_ZERO_BIT  = 1;

    // Frame lengths in bytes
    localparam int FRAME_LEN_RESULT = 1;
    localparam int FRAME_LEN_STATUS = 2;

    function automatic logic [DATA_W-1:0] pack_status(input logic carry,
                                                      input logic zero);
        logic [DATA_W-1:0] s;
        s = '0;
        s[STATUS_CARRY_BIT] = carry;
        s[STATUS_ZERO_BIT]  = zero;
        return s;
    endfunction

endpackage

// File: rtl/interface_tx.sv
// ----------------------------------------------------------------------------
// interface_tx
// Captures the ALU result and flags on completion and serialises a response
// frame (result byte, optionally followed by a status byte) to the UART
// transmitter using its start/busy/done handshake.
//
// Ports
//   i_clk               system clock, rising edge
//   i_reset             asynchronous active-low reset
//   i_alu_result        ALU result, valid with i_alu_result_ready
//   i_alu_carry         ALU carry flag
//   i_alu_zero          ALU zero flag
//   i_alu_result_ready  one-cycle pulse: result and flags valid
//   i_tx_busy           UART transmitter shifting a byte
//   i_tx_done           one-cycle pulse: UART finished current byte
//   o_tx_data           byte presented to the UART (registered)
//   o_tx_start          one-cycle request to send o_tx_data
//   o_busy              frame in progress
//   o_frame_done        one-cycle pulse after the last byte completes
//   o_overrun           sticky: result arrived while a frame was in progress
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for an ALU result
// SEND      | o_tx_data loaded; issue start as soon as the UART is not busy
// WAIT_DONE | byte handed to the UART; waiting for its done pulse
// DONE      | frame complete; o_frame_done pulses for this one cycle
// ----------------------------------------------------------------------------
module interface_tx
    import interface_tx_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_W,
    parameter bit SEND_STATUS = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_alu_carry,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_result_ready,
    input  logic                  i_tx_busy,
    input  logic                  i_tx_done,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_overrun
);

    localparam int FRAME_LEN = SEND_STATUS ? FRAME_LEN_STATUS : FRAME_LEN_RESULT;

    tx_state_t             state_q, state_d;
    logic                  byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] status_q, status_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  overrun_q, overrun_d;
    logic                  last_byte;

    // The result byte goes straight into the tx data register, which holds it
    // for the whole first byte; only the status byte needs a separate latch.
    assign last_byte = (int'(byte_idx_q) == FRAME_LEN - 1);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= 1'b0;
            status_q   <= '0;
            tx_data_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            status_q   <= status_d;
            tx_data_q  <= tx_data_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        status_d     = status_q;
        tx_data_d    = tx_data_q;
        o_tx_start   = 1'b0;
        o_frame_done = 1'b0;

        // DONE still counts as busy, so a result arriving on the way back to
        // IDLE is dropped and flagged rather than starting a new frame.
        overrun_d = overrun_q | (i_alu_result_ready && (state_q != ST_IDLE));

        unique case (state_q)
            ST_IDLE: begin
                if (i_alu_result_ready) begin
                    tx_data_d  = i_alu_result;
                    status_d   = pack_status(i_alu_carry, i_alu_zero);
                    byte_idx_d = 1'b0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!i_tx_busy) begin
                    o_tx_start = 1'b1;
                    state_d    = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // done wins over a simultaneous busy
                if (i_tx_done) begin
                    if (!last_byte) begin
                        byte_idx_d = 1'b1;
                        tx_data_d  = status_q;
                        state_d    = ST_SEND;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                o_frame_done = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_tx_data = tx_data_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_interface_tx.sv
module tb_interface_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // DUT a: SEND_STATUS=1
    logic [7:0] a_result;
    logic       a_carry, a_zero, a_ready, a_busy, a_done;
    logic [7:0] a_data;
    logic       a_start, a_obusy, a_fdone, a_ovr;

    // DUT b: SEND_STATUS=0
    logic [7:0] b_result;
    logic       b_carry, b_zero, b_ready, b_busy, b_done;
    logic [7:0] b_data;
    logic       b_start, b_obusy, b_fdone, b_ovr;

    interface_tx #(.DATA_WIDTH(8), .SEND_STATUS(1'b1)) dut_a (
        .i_clk(clk), .i_reset(rst_n),
        .i_alu_result(a_result), .i_alu_carry(a_carry), .i_alu_zero(a_zero),
        .i_alu_result_ready(a_ready), .i_tx_busy(a_busy), .i_tx_done(a_done),
        .o_tx_data(a_data), .o_tx_start(a_start), .o_busy(a_obusy),
        .o_frame_done(a_fdone), .o_overrun(a_ovr)
    );

    interface_tx #(.DATA_WIDTH(8), .SEND_STATUS(1'b0)) dut_b (
        .i_clk(clk), .i_reset(rst_n),
        .i_alu_result(b_result), .i_alu_carry(b_carry), .i_alu_zero(b_zero),
        .i_alu_result_ready(b_ready), .i_tx_busy(b_busy), .i_tx_done(b_done),
        .o_tx_data(b_data), .o_tx_start(b_start), .o_busy(b_obusy),
        .o_frame_done(b_fdone), .o_overrun(b_ovr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] ea, eb;
    int starts_a = 0, frames_a = 0, starts_b = 0, frames_b = 0;

    // Scoreboard: every start pulse pops the next expected byte.
    always @(negedge clk) begin
        if (a_start === 1'b1) begin
            starts_a++;
            n_checks++;
            if (qa.size() == 0)
                $display("FAIL sb_a: unexpected byte %h sent, required none", a_data);
            else begin
                ea = qa.pop_front();
                if (a_data !== ea)
                    $display("FAIL sb_a: tx_data %h, required %h", a_data, ea);
                else
                    n_pass++;
            end
        end
        if (a_fdone === 1'b1) frames_a++;
        if (b_start === 1'b1) begin
            starts_b++;
            n_checks++;
            if (qb.size() == 0)
                $display("FAIL sb_b: unexpected byte %h sent, required none", b_data);
            else begin
                eb = qb.pop_front();
                if (b_data !== eb)
                    $display("FAIL sb_b: tx_data %h, required %h", b_data, eb);
                else
                    n_pass++;
            end
        end
        if (b_fdone === 1'b1) frames_b++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ready_a(input logic [7:0] r, input logic c, input logic z);
        a_result = r; a_carry = c; a_zero = z; a_ready = 1'b1;
        step();
        a_ready = 1'b0;
    endtask

    task automatic wait_start_a(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (a_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL %s: tx_start not seen, required within 30 cycles", tag);
        else n_pass++;
    endtask

    task automatic wait_frame_a(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (a_fdone === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL %s: frame_done not seen, required within 30 cycles", tag);
        else n_pass++;
    endtask

    // Called at the negedge where start is high: UART goes busy, then done.
    task automatic ack_a(input int busy_cyc, input bit overlap);
        step();
        a_busy = 1'b1;
        repeat (busy_cyc) step();
        a_done = 1'b1;
        if (!overlap) a_busy = 1'b0;
        step();
        a_done = 1'b0;
        a_busy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_result = '0; a_carry = 0; a_zero = 0; a_ready = 0; a_busy = 0; a_done = 0;
        b_result = '0; b_carry = 0; b_zero = 0; b_ready = 0; b_busy = 0; b_done = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({a_start, a_obusy, a_fdone, a_ovr} !== 4'b0)
            $display("FAIL reset_ctl_a: start/busy/fdone/ovr %b, required 0000",
                     {a_start, a_obusy, a_fdone, a_ovr});
        else n_pass++;
        n_checks++;
        if (a_data !== 8'h00) $display("FAIL reset_data_a: tx_data %h, required 00", a_data);
        else n_pass++;
        n_checks++;
        if ({b_start, b_obusy, b_fdone, b_ovr, b_data} !== 12'h0)
            $display("FAIL reset_b: outputs %h, required 000",
                     {b_start, b_obusy, b_fdone, b_ovr, b_data});
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_frame();
        int s0, f0;
        s0 = starts_a; f0 = frames_a;
        qa.push_back(8'hA5);
        qa.push_back(8'h01);
        pulse_ready_a(8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if (a_start !== 1'b1) $display("FAIL latency: tx_start %b, required 1", a_start);
        else n_pass++;
        n_checks++;
        if (a_obusy !== 1'b1) $display("FAIL busy_in_send: busy %b, required 1", a_obusy);
        else n_pass++;
        ack_a(2, 1'b0);
        wait_start_a("status_start");
        ack_a(1, 1'b1);  // done and busy together: done must win
        wait_frame_a("basic_frame_done");
        @(negedge clk);
        n_checks++;
        if ({a_obusy, a_fdone} !== 2'b00)
            $display("FAIL basic_after: busy/fdone %b, required 00", {a_obusy, a_fdone});
        else n_pass++;
        n_checks++;
        if (starts_a - s0 != 2) $display("FAIL basic_starts: %0d, required 2", starts_a - s0);
        else n_pass++;
        n_checks++;
        if (frames_a - f0 != 1) $display("FAIL basic_frames: %0d, required 1", frames_a - f0);
        else n_pass++;
        step();
    endtask

    task automatic test_status_off();
        bit seen;
        qb.push_back(8'h00);
        b_result = 8'h00; b_carry = 1'b0; b_zero = 1'b1; b_ready = 1'b1;
        step();
        b_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b_start !== 1'b1) $display("FAIL b_latency: tx_start %b, required 1", b_start);
        else n_pass++;
        step();
        b_busy = 1'b1;
        step();
        b_busy = 1'b0; b_done = 1'b1;
        step();
        b_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b_fdone === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL b_frame_done: not seen, required within 30 cycles");
        else n_pass++;
        repeat (6) step();
        n_checks++;
        if (starts_b != 1) $display("FAIL b_starts: %0d, required 1", starts_b);
        else n_pass++;
        n_checks++;
        if (frames_b != 1) $display("FAIL b_frames: %0d, required 1", frames_b);
        else n_pass++;
        n_checks++;
        if (b_obusy !== 1'b0) $display("FAIL b_idle: busy %b, required 0", b_obusy);
        else n_pass++;
    endtask

    task automatic test_busy_hold();
        a_busy = 1'b1;
        qa.push_back(8'h5A);
        qa.push_back(8'h02);
        pulse_ready_a(8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (a_start !== 1'b0 || a_data !== 8'h5A)
                $display("FAIL busy_hold[%0d]: start %b data %h, required 0 5a", i, a_start, a_data);
            else n_pass++;
        end
        @(posedge clk);
        #1 a_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_start !== 1'b1) $display("FAIL busy_release: tx_start %b, required 1", a_start);
        else n_pass++;
        ack_a(1, 1'b0);
        wait_start_a("hold_status_start");
        ack_a(1, 1'b0);
        wait_frame_a("hold_frame_done");
        step();
    endtask

    task automatic test_overrun();
        int s0;
        n_checks++;
        if (a_ovr !== 1'b0) $display("FAIL overrun_pre: overrun %b, required 0", a_ovr);
        else n_pass++;
        s0 = starts_a;
        qa.push_back(8'hA5);
        qa.push_back(8'h01);
        pulse_ready_a(8'hA5, 1'b1, 1'b0);
        wait_start_a("ovr_first_start");
        step();
        pulse_ready_a(8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (a_ovr !== 1'b1) $display("FAIL overrun_set: overrun %b, required 1", a_ovr);
        else n_pass++;
        step();
        a_busy = 1'b1;
        step();
        a_busy = 1'b0; a_done = 1'b1;
        step();
        a_done = 1'b0;
        wait_start_a("ovr_status_start");
        ack_a(1, 1'b0);
        wait_frame_a("ovr_frame_done");
        // result arriving during DONE must be dropped
        a_result = 8'h77; a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        repeat (4) step();
        n_checks++;
        if (starts_a - s0 != 2) $display("FAIL ovr_starts: %0d, required 2", starts_a - s0);
        else n_pass++;
        n_checks++;
        if (a_obusy !== 1'b0) $display("FAIL done_ready_ignored: busy %b, required 0", a_obusy);
        else n_pass++;
        n_checks++;
        if (a_ovr !== 1'b1) $display("FAIL overrun_sticky: overrun %b, required 1", a_ovr);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int s0, f0;
        s0 = starts_a; f0 = frames_a;
        qa.push_back(8'h11);
        qa.push_back(8'h03);
        pulse_ready_a(8'h11, 1'b1, 1'b1);
        wait_start_a("rst_first_start");
        step();
        a_busy = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_start, a_obusy, a_fdone, a_ovr} !== 4'b0)
            $display("FAIL rst_mid_ctl: start/busy/fdone/ovr %b, required 0000",
                     {a_start, a_obusy, a_fdone, a_ovr});
        else n_pass++;
        n_checks++;
        if (a_data !== 8'h00) $display("FAIL rst_mid_data: tx_data %h, required 00", a_data);
        else n_pass++;
        qa.delete();
        a_busy = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        a_done = 1'b1;
        step();
        a_done = 1'b0;
        repeat (5) step();
        n_checks++;
        if (starts_a - s0 != 1) $display("FAIL rst_starts: %0d, required 1", starts_a - s0);
        else n_pass++;
        n_checks++;
        if (frames_a - f0 != 0) $display("FAIL rst_frames: %0d, required 0", frames_a - f0);
        else n_pass++;
        n_checks++;
        if (a_obusy !== 1'b0) $display("FAIL rst_idle: busy %b, required 0", a_obusy);
        else n_pass++;
    endtask

    task automatic test_idle_done();
        int s0, f0;
        s0 = starts_a; f0 = frames_a;
        for (int i = 0; i < 3; i++) begin
            a_done = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({a_start, a_obusy, a_fdone} !== 3'b000)
                $display("FAIL idle_done[%0d]: start/busy/fdone %b, required 000",
                         i, {a_start, a_obusy, a_fdone});
            else n_pass++;
            step();
            a_done = 1'b0;
            step();
        end
        n_checks++;
        if (starts_a != s0 || frames_a != f0)
            $display("FAIL idle_counts: starts %0d frames %0d, required 0 0",
                     starts_a - s0, frames_a - f0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_status_off();
        test_busy_hold();
        test_overrun();
        test_reset_mid_frame();
        test_idle_done();
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0)
            $display("FAIL sb_leftover: %0d/%0d bytes unsent, required 0/0", qa.size(), qb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
